fp_cmp_sched: RTL

Shared-resource scheduler for the floating-point compare unit in the EX stage. It arbitrates round-robin among `NUM_REQ` requesters, such as lanes or warp slots, that issue feq/flt/fle operations. It registers the granted operands, drives one internal `fp_cmp` instance, and returns the result through a registered, back-pressurable response port tagged with the requester index. It also keeps a saturating count of invalid-operation (NV) responses for the CSR/debug path.

---
 rtl/fp_cmp_sched.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp_cmp_sched.sv
// rtl/fp_cmp_sched.sv - round-robin scheduler in front of a shared FP compare unit
// fp_cmp is the combinational feq/flt/fle datapath; fp_cmp_sched arbitrates and pipelines it.

module fp_cmp (
    input  logic [64:0] iData1,
    input  logic [64:0] iData2,
    input  logic [2:0]  iRm,
    input  logic [9:0]  iClass1,
    input  logic [9:0]  iClass2,
    output logic [63:0] oResult,
    output logic [4:0]  oFlags
);

    logic        w_sign1;
    logic        w_sign2;
    logic [62:0] w_mag1;
    logic [62:0] w_mag2;
    logic        w_nan_any;
    logic        w_snan_any;
    logic        w_zero_both;
    logic        w_eq;
    logic        w_lt;

    // Operands arrive sign-extended to 65 bits; bit 64 carries the sign.
    assign w_sign1     = iData1[64];
    assign w_sign2     = iData2[64];
    assign w_mag1      = iData1[62:0];
    assign w_mag2      = iData2[62:0];
    assign w_nan_any   = iClass1[8] | iClass1[9] | iClass2[8] | iClass2[9];
    assign w_snan_any  = iClass1[8] | iClass2[8];
    assign w_zero_both = (iClass1[3] | iClass1[4]) & (iClass2[3] | iClass2[4]);

    assign w_eq = w_zero_both | ({w_sign1, w_mag1} == {w_sign2, w_mag2});

    always_comb begin
        w_lt = 1'b0;
        if (w_zero_both) begin
            w_lt = 1'b0;
        end else if (w_sign1 != w_sign2) begin
            w_lt = w_sign1;
        end else if (!w_sign1) begin
            w_lt = (w_mag1 < w_mag2);
        end else begin
            w_lt = (w_mag1 > w_mag2);
        end
    end

    // feq signals NV only on sNaN; the ordered compares signal it on any NaN.
    always_comb begin
        oResult = 64'd0;
        oFlags  = 5'd0;
        case (iRm)
            3'd2: begin
                oFlags[4]  = w_snan_any;
                oResult[0] = ~w_nan_any & w_eq;
            end
            3'd1: begin
                oFlags[4]  = w_nan_any;
                oResult[0] = ~w_nan_any & w_lt;
            end
            3'd0: begin
                oFlags[4]  = w_nan_any;
                oResult[0] = ~w_nan_any & (w_lt | w_eq);
            end
            default: begin
                oResult = 64'd0;
                oFlags  = 5'd0;
            end
        endcase
    end

endmodule

module fp_cmp_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 iClk,
    input  logic                 iRstn,
    input  logic [NUM_REQ-1:0]   iReqValid,
    output logic [NUM_REQ-1:0]   oReqReady,
    input  logic [NUM_REQ*65-1:0] iReqData1,
    input  logic [NUM_REQ*65-1:0] iReqData2,
    input  logic [NUM_REQ*3-1:0] iReqRm,
    input  logic [NUM_REQ*10-1:0] iReqClass1,
    input  logic [NUM_REQ*10-1:0] iReqClass2,
    output logic                 oRespValid,
    input  logic                 iRespReady,
    output logic [ID_W-1:0]      oRespId,
    output logic [63:0]          oRespResult,
    output logic [4:0]           oRespFlags,
    output logic [15:0]          oNvCount
);

    logic             r_s1_valid;
    logic [64:0]      r_s1_data1;
    logic [64:0]      r_s1_data2;
    logic [2:0]       r_s1_rm;
    logic [9:0]       r_s1_class1;
    logic [9:0]       r_s1_class2;
    logic [ID_W-1:0]  r_s1_id;

    logic             r_s2_valid;
    logic [ID_W-1:0]  r_s2_id;
    logic [63:0]      r_s2_result;
    logic [4:0]       r_s2_flags;

    logic [ID_W-1:0]  r_rr_ptr;
    logic [15:0]      r_nv_cnt;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_s1_free;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_grant_id;
    logic [ID_W-1:0]  w_scan_id;
    logic             w_grant_any;
    logic [64:0]      w_sel_data1;
    logic [64:0]      w_sel_data2;
    logic [2:0]       w_sel_rm;
    logic [9:0]       w_sel_class1;
    logic [9:0]       w_sel_class2;
    logic [63:0]      w_cmp_result;
    logic [4:0]       w_cmp_flags;

    assign w_s2_adv  = ~r_s2_valid | iRespReady;
    assign w_s1_adv  = r_s1_valid & w_s2_adv;
    assign w_s1_free = ~r_s1_valid | w_s1_adv;

    // Scan from rr_ptr upward; the ID_W-wide index wraps modulo NUM_REQ for free.
    always_comb begin
        w_grant     = '0;
        w_grant_id  = '0;
        w_grant_any = 1'b0;
        w_scan_id   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_id = r_rr_ptr + ID_W'(k);
            if (w_s1_free && !w_grant_any && iReqValid[w_scan_id]) begin
                w_grant_any = 1'b1;
                w_grant_id  = w_scan_id;
            end
        end
        if (w_grant_any) begin
            w_grant[w_grant_id] = 1'b1;
        end
    end

    assign oReqReady = w_grant;

    assign w_sel_data1  = iReqData1[int'(w_grant_id)*65 +: 65];
    assign w_sel_data2  = iReqData2[int'(w_grant_id)*65 +: 65];
    assign w_sel_rm     = iReqRm[int'(w_grant_id)*3 +: 3];
    assign w_sel_class1 = iReqClass1[int'(w_grant_id)*10 +: 10];
    assign w_sel_class2 = iReqClass2[int'(w_grant_id)*10 +: 10];

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_s1_valid  <= 1'b0;
            r_s1_data1  <= '0;
            r_s1_data2  <= '0;
            r_s1_rm     <= '0;
            r_s1_class1 <= '0;
            r_s1_class2 <= '0;
            r_s1_id     <= '0;
            r_rr_ptr    <= '0;
        end else if (w_grant_any) begin
            r_s1_valid  <= 1'b1;
            r_s1_data1  <= w_sel_data1;
            r_s1_data2  <= w_sel_data2;
            r_s1_rm     <= w_sel_rm;
            r_s1_class1 <= w_sel_class1;
            r_s1_class2 <= w_sel_class2;
            r_s1_id     <= w_grant_id;
            r_rr_ptr    <= w_grant_id + ID_W'(1);
        end else if (w_s1_adv) begin
            r_s1_valid  <= 1'b0;
        end
    end

    fp_cmp u_fp_cmp (
        .iData1  (r_s1_data1),
        .iData2  (r_s1_data2),
        .iRm     (r_s1_rm),
        .iClass1 (r_s1_class1),
        .iClass2 (r_s1_class2),
        .oResult (w_cmp_result),
        .oFlags  (w_cmp_flags)
    );

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_s2_valid  <= 1'b0;
            r_s2_id     <= '0;
            r_s2_result <= '0;
            r_s2_flags  <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid  <= 1'b1;
            r_s2_id     <= r_s1_id;
            r_s2_result <= w_cmp_result;
            r_s2_flags  <= w_cmp_flags;
        end else if (w_s2_adv) begin
            r_s2_valid  <= 1'b0;
        end
    end

    // NV counter sticks at all-ones so the debug path never sees a wrap.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_nv_cnt <= '0;
        end else if (r_s2_valid && iRespReady && r_s2_flags[4] && (r_nv_cnt != 16'hFFFF)) begin
            r_nv_cnt <= r_nv_cnt + 16'd1;
        end
    end

    assign oRespValid  = r_s2_valid;
    assign oRespId     = r_s2_id;
    assign oRespResult = r_s2_result;
    assign oRespFlags  = r_s2_flags;
    assign oNvCount    = r_nv_cnt;

endmodule
